// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver FSM states, oversampling points, baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int         OS_RATE    = 16;
  localparam logic [3:0] SAMPLE_MID = 4'd7;
  localparam logic [3:0] SAMPLE_END = 4'd15;

  // Rounded CLK_HZ / (OS_RATE * BAUD).
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (OS_RATE * baud) / 2) / (OS_RATE * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered FIFO: push visible at the head one cycle later; push while full is dropped unless a pop
// happens in the same cycle. Consumer backpressure is simply pop held low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 receiver with 16x oversampling: byte at out_data one cycle after the stop-bit sample.
// out_ready low holds the FIFO head; a full FIFO drops new bytes and raises sticky overrun.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clear
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_frontend: CLK_HZ/(16*BAUD) rounds below 1");
  end

  logic          rx_meta, rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  rx_state_e     state;
  logic [3:0]    os;
  logic [2:0]    bc;
  logic [7:0]    shift;
  logic          stop_sample, push, frame_set, overrun_set, pop_fire;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TW'(DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      os    <= '0;
      bc    <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          os    <= '0;
        end
        // Mid-bit check rejects short low glitches as false starts.
        START: if (tick) begin
          if (os == SAMPLE_MID) begin
            if (rx_s) state <= IDLE;
            else begin
              state <= DATA;
              os    <= '0;
              bc    <= '0;
            end
          end else os <= os + 1'b1;
        end
        DATA: if (tick) begin
          if (os == SAMPLE_END) begin
            shift[bc] <= rx_s;
            os        <= '0;
            if (bc == 3'd7) state <= STOP;
            else            bc    <= bc + 1'b1;
          end else os <= os + 1'b1;
        end
        STOP: if (tick) begin
          if (os == SAMPLE_END) begin
            os    <= '0;
            state <= rx_s ? IDLE : BREAK;
          end else os <= os + 1'b1;
        end
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_sample = tick && (state == STOP) && (os == SAMPLE_END);
  assign push        = stop_sample && rx_s;
  assign frame_set   = stop_sample && !rx_s;
  assign pop_fire    = out_valid && out_ready;
  assign overrun_set = push && fifo_full && !pop_fire;
  assign out_valid   = !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (push),
    .push_dat (shift),
    .pop      (out_ready),
    .pop_dat  (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   | (frame_err & ~err_clear);
      overrun   <= overrun_set | (overrun & ~err_clear);
    end
  end

  a_count_range: assert property (@(posedge CLK) disable iff (!RST_N) fifo_count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboarded bench: frames are driven bit by bit, expected bytes queued, a monitor checks handshakes.
module tb_uart_rx_frontend;

  localparam int CLK_HZ      = 6_400_000;
  localparam int BAUD        = 100_000;
  localparam int DEPTH       = 8;
  localparam int DIV         = 4;
  localparam int BIT         = 64;
  localparam int FRAME_TICKS = 152;  // 8 to mid-start, 8*16 data, 16 to stop sample

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, frame_err, overrun;

  uart_rx_frontend #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .rx        (rx),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clear (err_clear)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         rel_base = 0;
  int         hs_cnt = 0;
  logic [7:0] exp_q[$];
  bit         exp_overrun = 1'b0;
  bit         exp_frame_err = 1'b0;
  bit         tog_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  // Monitor: every handshake must match the head of the expected queue; a stalled head must not move.
  initial begin
    bit         prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge CLK);
      if (!RST_N) prev_hold = 1'b0;
      else begin
        if (prev_hold && out_valid) check("hold_stable", int'(out_data), int'(prev_data));
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=0x%0h required=none", out_data);
          end else check("rx_byte", int'(out_data), int'(exp_q.pop_front()));
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Reference: a good frame lands in the buffer if there is room (or a pop coincides), else overrun.
  task automatic expect_byte(input logic [7:0] d, input bit pop_same);
    if (exp_q.size() < DEPTH || pop_same) exp_q.push_back(d);
    else exp_overrun = 1'b1;
  endtask

  // Called #1 after a clock edge; leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick_n(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick_n(BIT);
    end
    rx = stop;
    tick_n(BIT);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check(name, exp_q.size(), 0);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick_n(1);
    err_clear = 1'b0;
    exp_overrun   = 1'b0;
    exp_frame_err = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int hs0, a, f, s;

    tick_n(3);
    RST_N = 1'b1;
    rel_base = cyc;
    tick_n(2);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);

    // Single byte, consumer always ready.
    out_ready = 1'b1;
    hs0 = hs_cnt;
    expect_byte(8'hA5, 1'b0);
    send_frame(8'hA5, 1'b1);
    tick_n(BIT);
    wait_drain("drain_a5", 200);
    check("a5_handshakes", hs_cnt - hs0, 1);
    check("a5_frame_err", int'(frame_err), int'(exp_frame_err));
    check("a5_overrun", int'(overrun), int'(exp_overrun));

    // Nine bytes into an eight-deep buffer with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      v = 8'(i);
      expect_byte(v, 1'b0);
      send_frame(v, 1'b1);
    end
    tick_n(BIT);
    check("ovr_valid", int'(out_valid), 1);
    check("ovr_head", int'(out_data), 0);
    check("ovr_flag", int'(overrun), int'(exp_overrun));
    out_ready = 1'b1;
    wait_drain("drain_ovr", 100);
    tick_n(BIT);
    check("ovr_empty_after", int'(out_valid), 0);
    pulse_clear();
    check("ovr_cleared", int'(overrun), int'(exp_overrun));

    // Bad stop bit followed by a held-low line, then a clean frame.
    send_frame(8'h3C, 1'b0);
    exp_frame_err = 1'b1;
    tick_n(200);
    check("fe_flag", int'(frame_err), int'(exp_frame_err));
    check("fe_no_byte", int'(out_valid), 0);
    rx = 1'b1;
    tick_n(BIT);
    expect_byte(8'h55, 1'b0);
    send_frame(8'h55, 1'b1);
    tick_n(BIT);
    wait_drain("drain_55", 200);
    check("fe_still_set", int'(frame_err), int'(exp_frame_err));
    pulse_clear();
    check("fe_cleared", int'(frame_err), int'(exp_frame_err));

    // Short low glitch on an idle line.
    rx = 1'b0;
    tick_n(20);
    rx = 1'b1;
    tick_n(100);
    check("glitch_no_byte", int'(out_valid), 0);
    check("glitch_frame_err", int'(frame_err), 0);
    check("glitch_overrun", int'(overrun), 0);
    expect_byte(8'hFF, 1'b0);
    send_frame(8'hFF, 1'b1);
    tick_n(BIT);
    wait_drain("drain_ff", 200);

    // Reset in the middle of a frame, with a byte sitting in the buffer.
    out_ready = 1'b0;
    v = 8'($urandom_range(1, 255));
    expect_byte(v, 1'b0);
    send_frame(v, 1'b1);
    tick_n(BIT);
    check("pre_rst_valid", int'(out_valid), 1);
    check("pre_rst_data", int'(out_data), int'(v));
    rx = 1'b0;
    tick_n(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b1 : 1'b0;
      tick_n(BIT);
    end
    tick_n(20);
    RST_N = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    rel_base = cyc;
    out_ready = 1'b1;
    tick_n(2 * BIT);
    check("rst_no_partial", int'(out_valid), 0);
    expect_byte(8'h7E, 1'b0);
    send_frame(8'h7E, 1'b1);
    tick_n(BIT);
    wait_drain("drain_7e", 200);

    // Full buffer, consumer pops in exactly the cycle the ninth stop bit is sampled.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 8'($urandom);
      expect_byte(v, 1'b0);
      send_frame(v, 1'b1);
    end
    tick_n(BIT);
    v = 8'($urandom);
    expect_byte(v, 1'b1);
    a = cyc - rel_base;
    f = ((a + 3) / DIV + 1) * DIV;
    s = f + DIV * (FRAME_TICKS - 1);
    fork
      send_frame(v, 1'b1);
      begin
        while ((cyc - rel_base) < s - 1) begin
          @(posedge CLK);
          #1;
        end
        out_ready = 1'b1;
        tick_n(1);
        out_ready = 1'b0;
      end
    join
    tick_n(BIT);
    check("edge_overrun", int'(overrun), int'(exp_overrun));
    check("edge_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_drain("drain_edge", 100);

    // Random bytes and gaps with a randomly stalling consumer.
    tog_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          v = 8'($urandom);
          expect_byte(v, 1'b0);
          send_frame(v, 1'b1);
          tick_n($urandom_range(0, 100));
        end
        tog_en = 1'b0;
      end
      while (tog_en) begin
        @(posedge CLK);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    tick_n(BIT);
    wait_drain("drain_rand", 200);
    check("rand_frame_err", int'(frame_err), int'(exp_frame_err));
    check("rand_overrun", int'(overrun), int'(exp_overrun));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
